keccak_pad_axis: RTL and testbench

Parametrised AXI-Stream pad10*1 padder for the SHA-3/Keccak datapath, sitting between the message ingress stream and the absorb stage. It passes message beats through unchanged and inserts the domain-separation byte after the last valid message byte. It zero-fills to the rate-block boundary and sets bit 7 of the final byte of that block. Unlike the fixed 16-bit padder, it supports any byte-multiple data width, a configurable rate, SHA3/SHAKE/Keccak domain modes and a full ready/valid handshake. It generates whole extra padding beats and blocks on its own.

---
 rtl/keccak_pad_axis.sv | 145 ++++++++++++++
 tb/tb_keccak_pad_axis.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_pad_axis.sv
// keccak_pad_axis: AXI-Stream pad10*1 padder for the Keccak/SHA-3 absorb path.
// Message beats pass through unchanged. After the last message byte the padder
// inserts the domain byte, zero-fills to the rate-block boundary and sets bit 7
// of the final block byte. Any padding beats and blocks are generated internally.
module keccak_pad_axis #(
    parameter int DATA_W     = 64,
    parameter int RATE_BYTES = 136
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic [1:0]                       mode,
    input  logic [DATA_W-1:0]                s_axis_tdata,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    input  logic [$clog2(DATA_W/8+1)-1:0]    s_axis_tuser,
    output logic [DATA_W-1:0]                m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast
);

    localparam int BYTES = DATA_W / 8;
    localparam int BPB   = RATE_BYTES / BYTES;
    localparam int UW    = $clog2(BYTES + 1);
    localparam int CNT_W = (BPB > 1) ? $clog2(BPB) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BPB - 1);
    localparam logic [UW-1:0]     N_FULL   = UW'(BYTES);
    localparam logic [DATA_W-1:0] END_BIT  = {8'h80, {(DATA_W-8){1'b0}}};

    typedef enum logic [1:0] {
        PASS,
        DS_PEND,
        FILL
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [7:0]        ds_q;
    logic [7:0]        ds_now;
    logic              load;
    logic              accept;
    logic              blk_end;
    logic [UW-1:0]     n_bytes;
    logic              full_last;
    logic [DATA_W-1:0] last_data;
    logic [DATA_W-1:0] pend_data;
    logic [DATA_W-1:0] fill_data;

    assign load          = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state == PASS) && load && ARESETN;
    assign accept        = s_axis_tvalid && s_axis_tready;
    // cnt is the block position of the next beat loaded into the output register.
    // Beats are never dropped, so this matches the count of output handshakes.
    assign blk_end       = (cnt == CNT_LAST);
    assign cnt_next      = blk_end ? '0 : cnt + 1'b1;

    // Domain-separation byte selected by the current mode input
    always_comb begin
        case (mode)
            2'd0:    ds_now = 8'h06;
            2'd1:    ds_now = 8'h1F;
            default: ds_now = 8'h01;
        endcase
    end

    // Candidate output beats: padded last beat, pending domain beat, fill beat
    always_comb begin
        n_bytes   = (s_axis_tuser >= N_FULL) ? N_FULL : s_axis_tuser;
        full_last = (n_bytes == N_FULL);
        last_data = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (i < 32'(n_bytes))
                last_data[8*i +: 8] = s_axis_tdata[8*i +: 8];
            else if (i == 32'(n_bytes))
                last_data[8*i +: 8] = ds_now;
        end
        if (blk_end)
            last_data = last_data | END_BIT;
        pend_data = {{(DATA_W-8){1'b0}}, ds_q} | (blk_end ? END_BIT : '0);
        fill_data = blk_end ? END_BIT : '0;
    end

    // Padding FSM with the registered output stage
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= PASS;
            cnt           <= '0;
            ds_q          <= 8'h06;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            case (state)
                PASS: begin
                    if (accept) begin
                        m_axis_tvalid <= 1'b1;
                        if (!s_axis_tlast) begin
                            m_axis_tdata <= s_axis_tdata;
                            m_axis_tlast <= 1'b0;
                            cnt          <= cnt_next;
                        end else begin
                            ds_q <= ds_now;
                            if (full_last) begin
                                // No room for the domain byte: it goes into its own beat.
                                m_axis_tdata <= s_axis_tdata;
                                m_axis_tlast <= 1'b0;
                                cnt          <= cnt_next;
                                state        <= DS_PEND;
                            end else begin
                                m_axis_tdata <= last_data;
                                m_axis_tlast <= blk_end;
                                cnt          <= cnt_next;
                                state        <= blk_end ? PASS : FILL;
                            end
                        end
                    end else begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                    end
                end
                DS_PEND: begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= pend_data;
                    m_axis_tlast  <= blk_end;
                    cnt           <= cnt_next;
                    state         <= blk_end ? PASS : FILL;
                end
                FILL: begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= fill_data;
                    m_axis_tlast  <= blk_end;
                    cnt           <= cnt_next;
                    state         <= blk_end ? PASS : FILL;
                end
                default: begin
                    state <= PASS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_pad_axis.sv
// Directed bench for keccak_pad_axis with DATA_W = 64 and RATE_BYTES = 136.
// Expected streams come from a byte-level pad10*1 reference model.
// Key beats are also compared against hand-computed constants.
module tb_keccak_pad_axis;

    localparam int DW = 64;
    localparam int RB = 136;
    localparam int BY = 8;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [3:0]    s_axis_tuser = '0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;

    keccak_pad_axis #(.DATA_W(DW), .RATE_BYTES(RB)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .mode          (mode),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  msg[$];
    logic [63:0] exp_d[$];
    logic        exp_l[$];
    logic [63:0] got_d[$];
    logic        got_l[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ds_of(input logic [1:0] m);
        case (m)
            2'd0:    return 8'h06;
            2'd1:    return 8'h1F;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [63:0] gd(input int i);
        if (i < got_d.size()) return got_d[i];
        return 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    // Reference: message || DS || zeros up to a rate multiple, last byte |= 0x80
    task automatic build_exp(input logic [7:0] ds);
        logic [7:0] p[$];
        logic [63:0] w;
        int nbeats;
        p = msg;
        p.push_back(ds);
        while ((p.size() % RB) != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        exp_d.delete();
        exp_l.delete();
        nbeats = p.size() / BY;
        for (int b = 0; b < nbeats; b++) begin
            w = '0;
            for (int k = 0; k < BY; k++) w[8*k +: 8] = p[b*BY + k];
            exp_d.push_back(w);
            exp_l.push_back(b == nbeats - 1);
        end
    endtask

    task automatic run_msg(input string name, input logic [1:0] m, input bit stall,
                           input int abort_after);
        int nb;
        int bi;
        int cyc;
        int nrem;
        bit done_in;
        bit seen_last;
        bit holding;
        logic [63:0] hold_d;
        logic        hold_l;
        logic [63:0] w;
        nb = (msg.size() + BY - 1) / BY;
        if (nb == 0) nb = 1;
        bi = 0; cyc = 0; done_in = 0; seen_last = 0; holding = 0;
        hold_d = '0; hold_l = 1'b0;
        build_exp(ds_of(m));
        got_d.delete();
        got_l.delete();
        mode = m;
        while (!seen_last && cyc < 3000) begin
            @(negedge ACLK);
            cyc++;
            if (holding) begin
                check({name, " hold_valid"}, 64'(m_axis_tvalid), 64'd1);
                check({name, " hold_data"}, m_axis_tdata, hold_d);
                check({name, " hold_last"}, 64'(m_axis_tlast), 64'(hold_l));
            end
            m_axis_tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (!done_in) begin
                s_axis_tvalid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                s_axis_tlast  = (bi == nb - 1);
                nrem = msg.size() - bi*BY;
                w = '0;
                for (int k = 0; k < BY; k++)
                    w[8*k +: 8] = (k < nrem) ? msg[bi*BY + k] : 8'hA5;
                s_axis_tdata = w;
                s_axis_tuser = s_axis_tlast ? 4'(nrem) : 4'($urandom_range(0, 8));
            end else begin
                // Last beat already taken: mode changes must not alter this message.
                s_axis_tvalid = 1'b0;
                mode = m ^ 2'd1;
            end
            #1;
            if (done_in && !(m_axis_tvalid && m_axis_tlast))
                check({name, " tready_pad"}, 64'(s_axis_tready), 64'd0);
            if (m_axis_tvalid && m_axis_tready) begin
                got_d.push_back(m_axis_tdata);
                got_l.push_back(m_axis_tlast);
                if (m_axis_tlast) seen_last = 1;
            end
            holding = m_axis_tvalid && !m_axis_tready;
            hold_d  = m_axis_tdata;
            hold_l  = m_axis_tlast;
            if (s_axis_tvalid && s_axis_tready) begin
                bi++;
                if (bi == nb) done_in = 1;
            end
            if (abort_after >= 0 && got_d.size() >= abort_after) break;
        end
        if (abort_after < 0) begin
            check({name, " done"}, 64'(seen_last), 64'd1);
            check({name, " beats"}, 64'(got_d.size()), 64'(exp_d.size()));
            for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
                check($sformatf("%s data[%0d]", name, i), got_d[i], exp_d[i]);
                check($sformatf("%s last[%0d]", name, i), 64'(got_l[i]), 64'(exp_l[i]));
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    task automatic set_len(input int n);
        msg.delete();
        for (int k = 0; k < n; k++) msg.push_back(8'(k));
    endtask

    initial begin
        logic [63:0] w;
        repeat (3) @(negedge ACLK);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // 1: empty message, SHA3
        msg.delete();
        run_msg("empty", 2'd0, 1'b0, -1);
        check("empty beat0", gd(0), 64'h0000000000000006);
        check("empty beat16", gd(16), 64'h8000000000000000);

        // 2: "abc", SHA3
        set_abc();
        run_msg("abc", 2'd0, 1'b0, -1);
        check("abc beat0", gd(0), 64'h0000000006636261);
        check("abc beat16", gd(16), 64'h8000000000000000);

        // 3: full-rate message forces an extra padding block
        set_len(136);
        run_msg("len136", 2'd0, 1'b0, -1);
        check("len136 beat0", gd(0), 64'h0706050403020100);
        check("len136 beat17", gd(17), 64'h0000000000000006);
        check("len136 beat33", gd(33), 64'h8000000000000000);

        // 4: domain byte and end bit share the last lane, SHAKE
        set_len(135);
        run_msg("len135", 2'd1, 1'b0, -1);
        check("len135 beat16", gd(16), 64'h9F86858483828180);

        // Keccak domain
        set_abc();
        run_msg("abc_keccak", 2'd2, 1'b0, -1);
        check("abc_keccak beat0", gd(0), 64'h0000000001636261);

        // 5: random stalls on both sides
        set_abc();
        run_msg("abc_stall", 2'd0, 1'b1, -1);
        set_len(136);
        run_msg("len136_stall", 2'd0, 1'b1, -1);
        set_len(135);
        run_msg("len135_stall", 2'd1, 1'b1, -1);

        // 6: reset during fill aborts, then a fresh message starts at cnt 0
        msg.delete();
        run_msg("abort", 2'd0, 1'b0, 5);
        ARESETN = 1'b0;
        #1;
        check("abort tvalid", 64'(m_axis_tvalid), 64'd0);
        check("abort tlast", 64'(m_axis_tlast), 64'd0);
        check("abort tready", 64'(s_axis_tready), 64'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        set_abc();
        run_msg("after_rst", 2'd0, 1'b0, -1);
        w = gd(0);
        check("after_rst beat0", w, 64'h0000000006636261);
        check("after_rst beat16", gd(16), 64'h8000000000000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
